// File: rtl/bram_arbiter_pkg.sv
// Shared types and constants for the BRAM arbiter slice.
// Requester ids tag reads so returning data can be routed.
package bram_arbiter_pkg;

  localparam int BRAM_ADDR_W = 19;
  localparam int REQ_ID_W    = 2;

  typedef enum logic [REQ_ID_W-1:0] {
    REQ_NONE = 2'd0,
    REQ_LD   = 2'd1,
    REQ_D    = 2'd2,
    REQ_I    = 2'd3
  } req_id_t;

endpackage

// File: rtl/bram_arbiter_if.sv
// Requester and BRAM-side bundle of the arbiter.
// master = requesters plus BRAM model, slave = arbiter.
interface bram_arbiter_if #(
  parameter int ADDR_W = 19
);
  logic              load_mode;
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_wdata;
  logic              ld_gnt;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic [31:0]       d_rdata;
  logic              d_valid;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_flush;
  logic              i_gnt;
  logic [31:0]       i_rdata;
  logic              i_valid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output load_mode,
    output ld_req, ld_addr, ld_wdata,
    input  ld_gnt,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rdata, d_valid,
    output i_req, i_addr, i_flush,
    input  i_gnt, i_rdata, i_valid,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  load_mode,
    input  ld_req, ld_addr, ld_wdata,
    output ld_gnt,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rdata, d_valid,
    input  i_req, i_addr, i_flush,
    output i_gnt, i_rdata, i_valid,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/bram_arbiter_rd_tag_pipe.sv
// Read tag shift register: tracks in-flight reads by requester,
// cancels fetch reads on flush and routes returning BRAM data.
module rd_tag_pipe
  import bram_arbiter_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int ID_W   = REQ_ID_W
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            push,
  input  logic [ID_W-1:0] push_id,
  input  logic            flush,
  input  logic [31:0]     rdata,
  output logic            d_valid,
  output logic [31:0]     d_rdata,
  output logic            i_valid,
  output logic [31:0]     i_rdata,
  output logic            busy
);

  localparam logic [ID_W-1:0] D_ID = ID_W'(REQ_D);
  localparam logic [ID_W-1:0] I_ID = ID_W'(REQ_I);

  logic [RD_LAT-1:0] vld;
  logic [ID_W-1:0]   ids [RD_LAT];
  logic [31:0]       d_hold;
  logic [31:0]       i_hold;
  logic              out_v;
  logic [ID_W-1:0]   out_id;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld <= '0;
      for (int k = 0; k < RD_LAT; k++) ids[k] <= '0;
      d_hold <= '0;
      i_hold <= '0;
    end else begin
      vld[0] <= push && !(flush && push_id == I_ID);
      ids[0] <= push_id;
      for (int k = 1; k < RD_LAT; k++) begin
        vld[k] <= vld[k-1] && !(flush && ids[k-1] == I_ID);
        ids[k] <= ids[k-1];
      end
      if (d_valid) d_hold <= rdata;
      if (i_valid) i_hold <= rdata;
    end
  end

  // Output stage is also cancelled by a flush in the cycle it returns.
  assign out_v   = vld[RD_LAT-1] && rstn;
  assign out_id  = ids[RD_LAT-1];
  assign d_valid = out_v && out_id == D_ID;
  assign i_valid = out_v && out_id == I_ID && !flush;
  assign d_rdata = d_valid ? rdata : d_hold;
  assign i_rdata = i_valid ? rdata : i_hold;
  assign busy    = |vld;

endmodule

// File: rtl/bram_arbiter.sv
// Single-port BRAM arbiter for loader, execute and fetch ports.
// Build option ARB_STATS_EN adds denial/override statistics counters.
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = BRAM_ADDR_W,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rstn,
  bram_arbiter_if.slave bus,
`ifdef ARB_STATS_EN
  output logic [31:0] stat_i_denied,
  output logic [31:0] stat_d_denied,
  output logic [31:0] stat_forced,
`endif
  output logic        busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0]     starve_cnt;
  logic              forced;
  logic              ld_gnt;
  logic              d_gnt;
  logic              i_gnt;
  logic              rd_push;
  logic [REQ_ID_W-1:0] rd_id;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              d_valid;
  logic              i_valid;
  logic [31:0]       d_rdata;
  logic [31:0]       i_rdata;

  always_comb begin
    forced = rstn && !bus.load_mode && bus.i_req
          && starve_cnt == SW'(STARVE_MAX);
    ld_gnt = rstn && bus.load_mode && bus.ld_req;
    d_gnt  = rstn && !bus.load_mode && bus.d_req && !forced;
    i_gnt  = rstn && !bus.load_mode && bus.i_req
          && (!bus.d_req || forced);
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      ld_gnt: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = bus.ld_addr;
        mem_wdata = bus.ld_wdata;
      end
      d_gnt: begin
        mem_en    = 1'b1;
        mem_we    = bus.d_we;
        mem_addr  = bus.d_addr;
        mem_wdata = bus.d_we ? bus.d_wdata : '0;
      end
      i_gnt: begin
        mem_en   = 1'b1;
        mem_addr = bus.i_addr;
      end
      default: ;
    endcase
    rd_push = (d_gnt && !bus.d_we) || i_gnt;
    rd_id   = i_gnt ? REQ_I : REQ_D;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      starve_cnt <= '0;
    end else if (bus.i_req && !i_gnt) begin
      if (starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  rd_tag_pipe #(
    .RD_LAT (RD_LAT),
    .ID_W   (REQ_ID_W)
  ) u_tag (
    .clk     (clk),
    .rstn    (rstn),
    .push    (rd_push),
    .push_id (rd_id),
    .flush   (bus.i_flush),
    .rdata   (bus.mem_rdata),
    .d_valid (d_valid),
    .d_rdata (d_rdata),
    .i_valid (i_valid),
    .i_rdata (i_rdata),
    .busy    (busy)
  );

  assign bus.ld_gnt    = ld_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.i_gnt     = i_gnt;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.d_valid   = d_valid;
  assign bus.d_rdata   = d_rdata;
  assign bus.i_valid   = i_valid;
  assign bus.i_rdata   = i_rdata;

`ifdef ARB_STATS_EN
  // Forced count only covers cycles where data actually lost to fetch.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_i_denied <= '0;
      stat_d_denied <= '0;
      stat_forced   <= '0;
    end else begin
      if (bus.i_req && !i_gnt && stat_i_denied != '1)
        stat_i_denied <= stat_i_denied + 1'b1;
      if (bus.d_req && !d_gnt && stat_d_denied != '1)
        stat_d_denied <= stat_d_denied + 1'b1;
      if (forced && bus.d_req && stat_forced != '1)
        stat_forced <= stat_forced + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed testbench for bram_arbiter with a 2-cycle BRAM model.
// Optional ARB_STATS_EN ports are connected when the macro is set.
module tb_bram_arbiter;
  import bram_arbiter_pkg::*;

  logic clk;
  logic rstn;
  logic busy;
  int   checks;
  int   failures;
`ifdef ARB_STATS_EN
  logic [31:0] stat_i_denied;
  logic [31:0] stat_d_denied;
  logic [31:0] stat_forced;
`endif

  bram_arbiter_if #(.ADDR_W(19)) bus ();

  bram_arbiter #(
    .ADDR_W     (19),
    .RD_LAT     (2),
    .STARVE_MAX (8)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .bus           (bus),
`ifdef ARB_STATS_EN
    .stat_i_denied (stat_i_denied),
    .stat_d_denied (stat_d_denied),
    .stat_forced   (stat_forced),
`endif
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [32];
  logic [31:0] rd_p0;
  logic [31:0] rd_p1;

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
    if (bus.mem_en && !bus.mem_we) rd_p0 <= mem[bus.mem_addr[4:0]];
    rd_p1 <= rd_p0;
  end
  assign bus.mem_rdata = rd_p1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ld_req   = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_wdata = '0;
    bus.d_req    = 1'b0;
    bus.d_we     = 1'b0;
    bus.d_addr   = '0;
    bus.d_wdata  = '0;
    bus.i_req    = 1'b0;
    bus.i_addr   = '0;
    bus.i_flush  = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    bus.load_mode = 1'b0;
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b exp=0", busy);
    end
    checks++;
    if ({bus.d_valid, bus.i_valid} !== 2'b00) begin
      failures++; $display("FAIL reset_valid got=%b%b exp=00", bus.d_valid, bus.i_valid);
    end
    checks++;
    if (bus.d_rdata !== 32'h0 || bus.i_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_rdata got=%h/%h exp=0/0", bus.d_rdata, bus.i_rdata);
    end
    checks++;
    if ({bus.mem_en, bus.ld_gnt, bus.d_gnt, bus.i_gnt} !== 4'b0) begin
      failures++; $display("FAIL reset_gnt got=%b exp=0000", {bus.mem_en, bus.ld_gnt, bus.d_gnt, bus.i_gnt});
    end
    tick();
  endtask

  task automatic test_load_mode();
    bus.load_mode = 1'b1;
    bus.ld_req = 1'b1;
    bus.ld_addr = 19'h10;
    bus.ld_wdata = 32'hDEADBEEF;
    bus.d_req = 1'b1;
    bus.d_addr = 19'h3;
    bus.i_req = 1'b1;
    bus.i_addr = 19'h4;
    #1;
    checks++;
    if ({bus.ld_gnt, bus.d_gnt, bus.i_gnt} !== 3'b100) begin
      failures++; $display("FAIL ld_gnts got=%b exp=100", {bus.ld_gnt, bus.d_gnt, bus.i_gnt});
    end
    checks++;
    if ({bus.mem_en, bus.mem_we} !== 2'b11 || bus.mem_addr !== 19'h10) begin
      failures++; $display("FAIL ld_mem got=en%b we%b a%h exp=en1 we1 a10", bus.mem_en, bus.mem_we, bus.mem_addr);
    end
    checks++;
    if (bus.mem_wdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL ld_wdata got=%h exp=deadbeef", bus.mem_wdata);
    end
    tick();
    idle();
    bus.load_mode = 1'b0;
    tick();
  endtask

  task automatic test_arbitration();
    bus.d_req = 1'b1;
    bus.d_addr = 19'd5;
    bus.i_req = 1'b1;
    bus.i_addr = 19'd6;
    #1;
    checks++;
    if ({bus.d_gnt, bus.i_gnt, bus.mem_we} !== 3'b100 || bus.mem_addr !== 19'd5) begin
      failures++; $display("FAIL arb_c0 got=d%b i%b we%b a%h exp=d1 i0 we0 a5", bus.d_gnt, bus.i_gnt, bus.mem_we, bus.mem_addr);
    end
    tick();
    bus.d_req = 1'b0;
    #1;
    checks++;
    if ({bus.d_gnt, bus.i_gnt} !== 2'b01 || bus.mem_addr !== 19'd6) begin
      failures++; $display("FAIL arb_c1 got=d%b i%b a%h exp=d0 i1 a6", bus.d_gnt, bus.i_gnt, bus.mem_addr);
    end
    tick();
    bus.i_req = 1'b0;
    #1;
    checks++;
    if ({bus.d_valid, bus.i_valid} !== 2'b10 || bus.d_rdata !== 32'hCAFE0005) begin
      failures++; $display("FAIL arb_c2 got=dv%b iv%b %h exp=dv1 iv0 cafe0005", bus.d_valid, bus.i_valid, bus.d_rdata);
    end
    tick();
    checks++;
    if ({bus.d_valid, bus.i_valid} !== 2'b01 || bus.i_rdata !== 32'h00600013) begin
      failures++; $display("FAIL arb_c3 got=dv%b iv%b %h exp=dv0 iv1 00600013", bus.d_valid, bus.i_valid, bus.i_rdata);
    end
    checks++;
    if (bus.d_rdata !== 32'hCAFE0005) begin
      failures++; $display("FAIL arb_hold got=%h exp=cafe0005", bus.d_rdata);
    end
    tick();
    checks++;
    if (bus.i_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL arb_c4 got=iv%b busy%b exp=iv0 busy0", bus.i_valid, busy);
    end
  endtask

  task automatic test_starvation();
    bus.d_req = 1'b1;
    bus.d_addr = 19'd8;
    bus.i_req = 1'b1;
    bus.i_addr = 19'd9;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++;
      if ({bus.d_gnt, bus.i_gnt} !== 2'b10) begin
        failures++; $display("FAIL starve_deny c=%0d got=d%b i%b exp=d1 i0", c, bus.d_gnt, bus.i_gnt);
      end
      tick();
    end
    #1;
    checks++;
    if ({bus.d_gnt, bus.i_gnt} !== 2'b01 || bus.mem_addr !== 19'd9) begin
      failures++; $display("FAIL starve_force got=d%b i%b a%h exp=d0 i1 a9", bus.d_gnt, bus.i_gnt, bus.mem_addr);
    end
    tick();
    #1;
    checks++;
    if ({bus.d_gnt, bus.i_gnt} !== 2'b10) begin
      failures++; $display("FAIL starve_clear got=d%b i%b exp=d1 i0", bus.d_gnt, bus.i_gnt);
    end
    tick();
    idle();
    tick();
    tick();
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL starve_drain got=%b exp=0", busy);
    end
  endtask

  task automatic test_flush();
    bus.i_req = 1'b1;
    bus.i_addr = 19'd6;
    #1;
    checks++;
    if (bus.i_gnt !== 1'b1) begin
      failures++; $display("FAIL flush_igrant got=%b exp=1", bus.i_gnt);
    end
    tick();
    bus.i_req = 1'b0;
    bus.i_flush = 1'b1;
    bus.d_req = 1'b1;
    bus.d_addr = 19'd5;
    #1;
    checks++;
    if (bus.d_gnt !== 1'b1) begin
      failures++; $display("FAIL flush_dgrant got=%b exp=1", bus.d_gnt);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.i_valid !== 1'b0) begin
      failures++; $display("FAIL flush_c2 got=%b exp=0", bus.i_valid);
    end
    tick();
    checks++;
    if ({bus.d_valid, bus.i_valid} !== 2'b10 || bus.d_rdata !== 32'hCAFE0005) begin
      failures++; $display("FAIL flush_c3 got=dv%b iv%b %h exp=dv1 iv0 cafe0005", bus.d_valid, bus.i_valid, bus.d_rdata);
    end
    tick();
    bus.i_req = 1'b1;
    bus.i_addr = 19'd6;
    bus.i_flush = 1'b1;
    #1;
    checks++;
    if (bus.i_gnt !== 1'b1) begin
      failures++; $display("FAIL flush_same_gnt got=%b exp=1", bus.i_gnt);
    end
    tick();
    idle();
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL flush_same_busy got=%b exp=0", busy);
    end
    tick();
    checks++;
    if (bus.i_valid !== 1'b0) begin
      failures++; $display("FAIL flush_same_iv got=%b exp=0", bus.i_valid);
    end
    tick();
  endtask

  task automatic test_reset_inflight();
    bus.d_req = 1'b1;
    bus.d_addr = 19'd5;
    tick();
    bus.d_req = 1'b0;
    bus.i_req = 1'b1;
    bus.i_addr = 19'd6;
    #1;
    checks++;
    if (bus.i_gnt !== 1'b1) begin
      failures++; $display("FAIL rst_fl_igrant got=%b exp=1", bus.i_gnt);
    end
    tick();
    idle();
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.d_valid !== 1'b0) begin
      failures++; $display("FAIL rst_fl_dv got=%b exp=0", bus.d_valid);
    end
    tick();
    rstn = 1'b1;
    #1;
    checks++;
    if ({busy, bus.d_gnt, bus.i_gnt, bus.d_valid, bus.i_valid} !== 5'b0) begin
      failures++; $display("FAIL rst_fl_after got=%b exp=00000", {busy, bus.d_gnt, bus.i_gnt, bus.d_valid, bus.i_valid});
    end
    checks++;
    if (bus.d_rdata !== 32'h0) begin
      failures++; $display("FAIL rst_fl_rdata got=%h exp=0", bus.d_rdata);
    end
    tick();
    checks++;
    if ({bus.d_valid, bus.i_valid} !== 2'b00) begin
      failures++; $display("FAIL rst_fl_late got=%b exp=00", {bus.d_valid, bus.i_valid});
    end
    tick();
  endtask

  task automatic test_store_load();
    bus.d_req = 1'b1;
    bus.d_we = 1'b1;
    bus.d_addr = 19'd7;
    bus.d_wdata = 32'h12345678;
    #1;
    checks++;
    if ({bus.d_gnt, bus.mem_we} !== 2'b11 || bus.mem_wdata !== 32'h12345678) begin
      failures++; $display("FAIL st_issue got=g%b we%b %h exp=g1 we1 12345678", bus.d_gnt, bus.mem_we, bus.mem_wdata);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL st_notag got=%b exp=0", busy);
    end
    bus.d_we = 1'b0;
    bus.d_wdata = '0;
    #1;
    checks++;
    if ({bus.d_gnt, bus.mem_we} !== 2'b10) begin
      failures++; $display("FAIL ldr_issue got=g%b we%b exp=g1 we0", bus.d_gnt, bus.mem_we);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.d_valid !== 1'b0) begin
      failures++; $display("FAIL ldr_early got=%b exp=0", bus.d_valid);
    end
    tick();
    checks++;
    if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'h12345678) begin
      failures++; $display("FAIL ldr_data got=v%b %h exp=v1 12345678", bus.d_valid, bus.d_rdata);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int k = 0; k < 32; k++) mem[k] = 32'h0;
    mem[5] = 32'hCAFE0005;
    mem[6] = 32'h00600013;
    mem[8] = 32'h88880008;
    mem[9] = 32'h99990009;
    rd_p0 = '0;
    rd_p1 = '0;
    test_reset();
    test_load_mode();
    test_arbitration();
    test_starvation();
    test_flush();
    test_reset_inflight();
    test_store_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Shares the single-port instruction/data BRAM between three requesters: the program loader (UART boot), the execute stage load/store port, and the instruction fetch port.
- Sits between the fetch/execute units and the BRAM macro; issues at most one BRAM access per cycle.
- Tags each read with its requester and returns read data after the fixed BRAM latency.
- Lets the pipeline controller stall fetch and execute on port conflicts.

Parameters:
- ADDR_W, 19, word-address width of BRAM.
- RD_LAT, 2, BRAM read latency in cycles (1..4).
- STARVE_MAX, 8, consecutive denied fetch cycles before fetch is forced to win.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- load_mode  in  1  1 = loader phase (only loader served); 0 = exec phase (loader ignored)
- ld_req  in  1  loader write request
- ld_addr  in  ADDR_W  loader write address
- ld_wdata  in  32  loader write data
- ld_gnt  out  1  loader write accepted this cycle
- d_req  in  1  execute memory request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  32  store data
- d_gnt  out  1  data request accepted this cycle
- d_rdata  out  32  load data
- d_valid  out  1  d_rdata valid pulse
- i_req  in  1  fetch request
- i_addr  in  ADDR_W  fetch address
- i_flush  in  1  hazard redirect; cancel in-flight fetch reads
- i_gnt  out  1  fetch accepted this cycle
- i_rdata  out  32  fetched instruction
- i_valid  out  1  i_rdata valid pulse
- mem_en  out  1  BRAM enable
- mem_we  out  1  BRAM write enable
- mem_addr  out  ADDR_W  BRAM address
- mem_wdata  out  32  BRAM write data
- mem_rdata  in  32  BRAM read data, RD_LAT cycles after issue
- busy  out  1  any read in flight

Behaviour:
- Handshake: requester holds req, address and data stable until its gnt is high. gnt is combinational, asserted in the same cycle as the mem_* issue. A requester may re-request in the cycle after gnt.
- Arbitration in load_mode=1: only the loader is eligible; d_req and i_req are never granted.
- Arbitration in load_mode=0: data beats fetch, except when starve_cnt == STARVE_MAX, where fetch wins that cycle. The loader is ignored.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, when i_req is high and not granted.
  - Clears on i_gnt or when i_req is low.
- mem_* signals come combinationally from the winner. mem_en=0 and the other mem_* signals are 0 when nothing is granted. Loader accesses are always writes; fetch accesses are always reads.
- Read tag pipeline: a shift register of RD_LAT stages, each holding {valid, id}.
  - Push on each granted read, with id = REQ_D or REQ_I.
  - At the output, mem_rdata routes to d_rdata/d_valid or i_rdata/i_valid according to id.
  - rdata outputs hold their last value; valid is a one-cycle pulse.
- Writes push no tag; there is no write response beyond gnt.
- i_flush: clears the valid bit of every REQ_I tag in the pipeline in that same cycle, including a read issued that cycle. Data tags are unaffected. i_valid stays low for every read cancelled by the flush.
- busy = OR of all pipeline valid bits.
- Simultaneous events:
  - A flush and a fetch grant in the same cycle: the new read is cancelled.
  - A load_mode change takes effect for arbitration the same cycle; in-flight reads still complete.
- Reset, applied at any time: pipeline cleared, starve_cnt=0, all valid/gnt outputs 0, d_rdata=i_rdata=0. Reads in flight are dropped silently.
- Width: addresses are word addresses; no byte enables; no wrap handling (the address is passed through).

Optional Feature:
- ARB_STATS_EN defined: adds three 32-bit saturating counters, exposed on output ports stat_i_denied, stat_d_denied and stat_forced.
  - stat_i_denied counts cycles with i_req and no i_gnt.
  - stat_d_denied counts cycles with d_req and no d_gnt.
  - stat_forced counts starvation overrides.
  - All three clear on reset.
- ARB_STATS_EN undefined: the counters and ports are absent; behaviour is otherwise identical.

Decomposition:
- Shared package constant: enum req_id_t {REQ_NONE, REQ_LD, REQ_D, REQ_I}, 2 bits.
- Shared package constant: BRAM_ADDR_W = 19, which is also the default for ADDR_W.
- Sub-module rd_tag_pipe (parameters RD_LAT and id width): implements the shift register, the flush-by-id clear and the output decode.

Test Plan:
- load_mode=1, ld_req with addr 0x10 and data 0xDEADBEEF, plus i_req and d_req high -> only ld_gnt asserted; mem_we=1, mem_addr=0x10.
- load_mode=0, d_req (load, addr 5) and i_req (addr 6) in the same cycle -> d_gnt at cycle 0, i_gnt at cycle 1; d_valid at cycle 2 and i_valid at cycle 3 (RD_LAT=2), each carrying the corresponding BRAM word.
- d_req held high continuously with i_req high -> fetch is denied 8 cycles; on the 9th cycle i_gnt=1 and d_gnt=0; starve_cnt returns to 0.
- Fetch granted at cycle 0, i_flush at cycle 1 -> i_valid never pulses. A data load issued at cycle 1 still gets d_valid at cycle 3.
- rstn low for 1 cycle while 2 reads are in flight -> no valid pulse afterwards; busy=0 and gnt=0 the cycle after reset.
- Store: d_we=1, addr 7, data 0x12345678, then a load from addr 7 -> d_rdata=0x12345678 with d_valid 2 cycles after the load's d_gnt.
